// File: rtl/bitop_arbiter_pkg.sv
// Shared constants for the two-requester bitwise-operation arbiter:
// operation codes and FSM state encoding.
package bitop_arbiter_pkg;

  typedef logic [1:0] op_t;
  typedef logic [1:0] state_t;

  localparam op_t OP_AND = 2'b00;
  localparam op_t OP_OR  = 2'b01;
  localparam op_t OP_XOR = 2'b10;
  localparam op_t OP_NOR = 2'b11;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_EXEC = 2'b01;
  localparam state_t ST_RESP = 2'b10;

endpackage

// File: rtl/bitop_arbiter_bitop_unit.sv
// Combinational bitwise datapath: applies one of AND/OR/XOR/NOR across WIDTH bits.
module bitop_unit
  import bitop_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = ~(a | b);
    endcase
  end

endmodule

// File: rtl/bitop_arbiter.sv
// Round-robin arbiter between two requesters feeding a shared bitwise unit;
// each accepted operation passes IDLE -> EXEC -> RESP before the next grant.
module bitop_arbiter
  import bitop_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data
);

  logic [1:0]       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [WIDTH-1:0] unit_y;
  logic             idle;
  logic             gnt0;
  logic             gnt1;

  // rst_n gates the grants so no ready leaks out while reset is held.
  always_comb begin
    idle = (state_q == ST_IDLE) && rst_n;
    gnt0 = idle && req0_valid && (!req1_valid || !ptr_q);
    gnt1 = idle && req1_valid && (!req0_valid ||  ptr_q);
  end

  bitop_unit #(.WIDTH(WIDTH)) u_unit (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (unit_y)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          state_d = ST_EXEC;
          id_d    = gnt1;
          op_d    = gnt1 ? req1_op : req0_op;
          a_d     = gnt1 ? req1_a  : req0_a;
          b_d     = gnt1 ? req1_b  : req0_b;
          // The loser of this grant becomes the preferred requester.
          ptr_d   = gnt0;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = unit_y;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      op_q        <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_bitop_arbiter.sv
// Self-checking bench for bitop_arbiter: directed vector table, hand-written
// stall/reset/alternation sequences, and a randomized run against a transaction model.
module tb_bitop_arbiter;
  import bitop_arbiter_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
  } vec_t;

  vec_t vecs[6];

  bitop_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic clear_reqs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 2'b00; req1_op = 2'b00;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_reqs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated transaction from requester `id`; called at a negedge with the DUT idle.
  task automatic run_one(input bit id, input vec_t v, input int idx);
    rsp_ready = 1'b1;
    req0_valid = !id; req1_valid = id;
    if (id) begin req1_op = v.op; req1_a = v.a; req1_b = v.b; end
    else    begin req0_op = v.op; req0_a = v.a; req0_b = v.b; end
    #1;
    chk($sformatf("vec%0d req0_ready", idx), req0_ready, !id);
    chk($sformatf("vec%0d req1_ready", idx), req1_ready, id);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~req0_a; req1_a = ~req1_a; req0_op = ~req0_op; req1_op = ~req1_op;
    #1;
    chk($sformatf("vec%0d exec rsp_valid", idx), rsp_valid, 1'b0);
    @(negedge clk);
    #1;
    chk($sformatf("vec%0d rsp_valid", idx), rsp_valid, 1'b1);
    chk($sformatf("vec%0d rsp_id", idx), rsp_id, id);
    chk($sformatf("vec%0d rsp_data", idx), rsp_data, v.y);
    @(negedge clk);
  endtask

  bit           m_busy;
  int           m_wait;
  bit           m_pref;
  bit           m_id;
  logic [W-1:0] m_data;

  initial begin
    vecs[0] = '{OP_AND, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000};
    vecs[1] = '{OP_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
    vecs[2] = '{OP_OR,  32'h80000001, 32'h00000002, 32'h80000003};
    vecs[3] = '{OP_XOR, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555};
    vecs[4] = '{OP_AND, 32'hDEADBEEF, 32'hFFFF0000, 32'hDEAD0000};
    vecs[5] = '{OP_NOR, 32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F};

    // Reset state, with both requesters asserting valid.
    rst_n = 1'b0;
    clear_reqs();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("rst req0_ready", req0_ready, 1'b0);
    chk("rst req1_ready", req1_ready, 1'b0);
    chk("rst rsp_valid", rsp_valid, 1'b0);
    chk("rst rsp_id", rsp_id, 1'b0);
    chk("rst rsp_data", rsp_data, '0);
    @(negedge clk);
    clear_reqs();
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_one(i[0], vecs[i], i);

    // Both requesters valid every cycle: grants alternate 0,1,0,1.
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_XOR; req0_a = 32'hAAAAAAAA; req0_b = 32'hFFFFFFFF;
    req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 32'h12345678; req1_b = 32'h12345678;
    for (int cyc = 0; cyc < 12; cyc++) begin
      int k;
      int ph;
      k = cyc / 3;
      ph = cyc % 3;
      #1;
      chk($sformatf("alt c%0d req0_ready", cyc), req0_ready, (ph == 0) && (k % 2 == 0));
      chk($sformatf("alt c%0d req1_ready", cyc), req1_ready, (ph == 0) && (k % 2 == 1));
      chk($sformatf("alt c%0d rsp_valid", cyc), rsp_valid, ph == 2);
      if (ph == 2) begin
        chk($sformatf("alt c%0d rsp_id", cyc), rsp_id, k % 2);
        chk($sformatf("alt c%0d rsp_data", cyc), rsp_data,
            (k % 2 == 0) ? 32'h55555555 : 32'h00000000);
      end
      @(negedge clk);
    end

    // Consumer stalls in RESP for five cycles while req1 waits.
    do_reset();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = OP_AND; req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = OP_OR; req1_a = 32'h00000001; req1_b = 32'h00000002;
    #1;
    chk("stall exec req1_ready", req1_ready, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall%0d rsp_valid", i), rsp_valid, 1'b1);
      chk($sformatf("stall%0d rsp_data", i), rsp_data, 32'h0F0F0000);
      chk($sformatf("stall%0d rsp_id", i), rsp_id, 1'b0);
      chk($sformatf("stall%0d req1_ready", i), req1_ready, 1'b0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("stall release req1_ready", req1_ready, 1'b0);
    @(negedge clk);
    #1;
    chk("stall next req1_ready", req1_ready, 1'b1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("stall req1 rsp_valid", rsp_valid, 1'b1);
    chk("stall req1 rsp_id", rsp_id, 1'b1);
    chk("stall req1 rsp_data", rsp_data, 32'h00000003);
    @(negedge clk);

    // Reset pulsed during EXEC aborts the operation.
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_NOR; req0_a = '0; req0_b = '0;
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort rsp_valid", rsp_valid, 1'b0);
    chk("abort rsp_id", rsp_id, 1'b0);
    chk("abort rsp_data", rsp_data, '0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op = OP_AND; req0_a = 32'h00000001; req0_b = 32'h00000003;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("abort%0d rsp_valid", i), rsp_valid, 1'b0);
      chk($sformatf("abort%0d ready0", i), req0_ready, 1'b0);
      chk($sformatf("abort%0d ready1", i), req1_ready, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-rst tie req0_ready", req0_ready, 1'b1);
    chk("post-rst tie req1_ready", req1_ready, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("post-rst exec rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    #1;
    chk("post-rst rsp_valid", rsp_valid, 1'b1);
    chk("post-rst rsp_id", rsp_id, 1'b0);
    chk("post-rst rsp_data", rsp_data, 32'h00000001);
    @(negedge clk);

    // Randomized traffic against a transaction-level model.
    do_reset();
    m_busy = 1'b0; m_wait = 0; m_pref = 1'b0; m_id = 1'b0; m_data = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit g0, g1;
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_op = 2'($urandom_range(0, 3));
      req1_op = 2'($urandom_range(0, 3));
      req0_a = $urandom; req0_b = $urandom;
      req1_a = $urandom; req1_b = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      g0 = 1'b0; g1 = 1'b0;
      if (!m_busy) begin
        if (req0_valid && req1_valid) begin g0 = !m_pref; g1 = m_pref; end
        else begin g0 = req0_valid; g1 = req1_valid; end
      end
      chk($sformatf("rnd c%0d req0_ready", cyc), req0_ready, g0);
      chk($sformatf("rnd c%0d req1_ready", cyc), req1_ready, g1);
      chk($sformatf("rnd c%0d rsp_valid", cyc), rsp_valid, m_busy && (m_wait == 0));
      if (m_busy && (m_wait == 0)) begin
        chk($sformatf("rnd c%0d rsp_id", cyc), rsp_id, m_id);
        chk($sformatf("rnd c%0d rsp_data", cyc), rsp_data, m_data);
      end
      if (g0 || g1) begin
        m_busy = 1'b1;
        m_wait = 1;
        m_id   = g1;
        m_data = g1 ? ref_op(req1_op, req1_a, req1_b) : ref_op(req0_op, req0_a, req0_b);
        m_pref = !g1;
      end else if (m_busy) begin
        if (m_wait > 0) m_wait--;
        else if (rsp_ready) m_busy = 1'b0;
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitop_arbiter.md
BITOP_ARBITER -- requirements
Module: bitop_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester N has an operation pending.
REQ-005 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: requester N's operation is accepted this cycle.
REQ-006 The block SHALL have ports req0_op and req1_op, input, 2 bits each: operation code (00 AND, 01 OR, 10 XOR, 11 NOR).
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a and req1_b, input, WIDTH bits each: operands.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit: a result is presented.
REQ-009 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-010 The block SHALL have port rsp_id, output, 1 bit: index of the requester that owns the result.
REQ-011 The block SHALL have port rsp_data, output, WIDTH bits: the result.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-013 In IDLE, with any reqN_valid high, the block SHALL grant one requester: reqN_ready high combinationally in that cycle; move to EXEC at the next edge.
REQ-014 At the grant edge, the block SHALL latch the granted op, a, b and id into internal registers.
REQ-015 reqN_ready SHALL be high only in IDLE and only when reqN_valid is high; at most one ready SHALL be high in any cycle.
REQ-016 Arbitration SHALL be round-robin: a 1-bit pointer names the preferred requester.
REQ-017 When both requesters are valid, the block SHALL grant the requester named by the pointer.
REQ-018 When only one requester is valid, the block SHALL grant it regardless of the pointer.
REQ-019 At each grant, the pointer SHALL be set to the non-granted index.
REQ-020 In EXEC, the block SHALL compute the latched operation bitwise over WIDTH bits, register the result into rsp_data and the id into rsp_id, and move to RESP.
REQ-021 In RESP, rsp_valid SHALL be high and rsp_data and rsp_id SHALL hold steady until rsp_ready is sampled high; the block SHALL then return to IDLE at that edge.
REQ-022 Latency: from a grant at edge T, rsp_valid SHALL be high from edge T+2.
REQ-023 Throughput: one operation per 3 cycles with rsp_ready held high; no grant SHALL occur in EXEC or RESP.
REQ-024 Requester inputs SHALL be ignored outside the grant cycle; changes while not granted SHALL have no effect.
REQ-025 rsp_ready while rsp_valid is low SHALL be ignored.

Reset
REQ-026 While rst_n is low, asynchronously: state SHALL be IDLE, pointer 0, rsp_valid 0, rsp_id 0, rsp_data 0, latched operands 0.
REQ-027 req0_ready and req1_ready SHALL be 0 while rst_n is low.
REQ-028 Reset asserted in EXEC or RESP SHALL abort the operation; no response for it SHALL ever be produced.
REQ-029 On rst_n release, the first grant SHALL follow REQ-013 with pointer 0, so req0 wins a tie.

Structure
REQ-030 A shared package SHALL hold the op-code constants (OP_AND, OP_OR, OP_XOR, OP_NOR) and the FSM state encoding.
REQ-031 The datapath SHALL be a separate combinational sub-module bitop_unit (inputs op, a, b; output y, WIDTH bits), instantiated once and fed from the latched registers.

Verification
REQ-032 Reset, then req0 only, op=00, a=0xFFFF0000, b=0x0F0F0F0F, rsp_ready=1 -> req0_ready high in grant cycle; two edges later rsp_valid=1, rsp_id=0, rsp_data=0x0F0F0000.
REQ-033 Both valid every cycle, ops XOR, req0 a=0xAAAAAAAA b=0xFFFFFFFF, req1 a=0x12345678 b=0x12345678 -> grants alternate 0,1,0,1; responses 0x55555555 (id 0) and 0x00000000 (id 1).
REQ-034 NOR with a=0, b=0 and OR with a=0x80000001, b=0x00000002 -> 0xFFFFFFFF and 0x80000003.
REQ-035 rsp_ready held low 5 cycles in RESP while req1_valid=1 -> rsp_valid, rsp_data and rsp_id stable; req1_ready stays 0; req1 granted the cycle after the first rsp_ready=1 edge.
REQ-036 rst_n pulsed low during EXEC -> rsp_valid never asserts for that operation; all outputs 0; after release, a tie grants req0.
